// File: rtl/mpi_eth_pkg.sv
// rtl/mpi_eth_pkg.sv - shared types and constants for the MPI-over-Ethernet receive parser
//
// Purpose: parser state encoding, header bit positions, the default ethertype,
//          the packed MPI header layout, and the payload flit-count helper.
// Ports:   none (package).

package mpi_eth_pkg;

  typedef enum logic [2:0] {
    ST_ETH0,
    ST_ETH1,
    ST_MPI,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  // flit0 = {dst_mac, src_mac[47:32]}
  localparam int DST_MAC_HI    = 63;
  localparam int DST_MAC_LO    = 16;
  localparam int SRC_MAC_UP_HI = 15;
  localparam int SRC_MAC_UP_LO = 0;
  // flit1 = {src_mac[31:0], ethertype, 16'h0}
  localparam int SRC_MAC_DN_HI = 63;
  localparam int SRC_MAC_DN_LO = 32;
  localparam int ETYPE_HI      = 31;
  localparam int ETYPE_LO      = 16;
  // flit2 = {dst_rank, src_rank, msg_type, size}
  localparam int RANK_HI       = 63;
  localparam int RANK_LO       = 48;
  localparam int SIZE_HI       = 31;
  localparam int SIZE_LO       = 0;

  localparam logic [15:0] DEFAULT_ETHERTYPE = 16'h88b5;

  typedef struct packed {
    logic [15:0] dst_rank;
    logic [7:0]  src_rank;
    logic [7:0]  msg_type;
    logic [31:0] size;
  } mpi_hdr_t;

  // Number of 64-bit flits needed to carry 'words' 32-bit words.
  function automatic logic [31:0] flits_for_words(input logic [31:0] words);
    return {1'b0, words[31:1]} + {31'd0, words[0]};
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - two-entry register slice for a data/keep/last stream
//
// Purpose: decouples upstream ready from downstream ready; o_ready depends only
//          on occupancy, so there is no combinational path from i_ready to o_ready.
// Ports:   i_clk, i_rst           clock, asynchronous active-high reset
//          i_data/i_keep/i_last   input beat, i_valid / o_ready handshake
//          o_data/o_keep/o_last   output beat, o_valid / i_ready handshake

module axis_skid_buf #(
  parameter int DW = 64,
  parameter int KW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_data,
  input  logic [KW-1:0] i_keep,
  input  logic          i_last,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic [KW-1:0] o_keep,
  output logic          o_last,
  output logic          o_valid,
  input  logic          i_ready
);

  localparam int EW = DW + KW + 1;

  logic [EW-1:0] r_mem [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_ready = (r_cnt != 2'd2);
  assign o_valid = (r_cnt != 2'd0);
  assign {o_last, o_keep, o_data} = r_mem[r_rptr];

  assign w_push = i_valid & o_ready;
  assign w_pop  = o_valid & i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {i_last, i_keep, i_data};
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/mpi_eth_rx_parser.sv
// rtl/mpi_eth_rx_parser.sv - filters Ethernet/MPI frames and forwards the MPI payload
//
// Purpose: parses {eth header, MPI header, payload} frames from a 64-bit stream,
//          drops frames for other MACs/ethertypes/ranks, publishes the MPI header
//          on a sideband and emits the payload with exact keep/last.
// Ports:   clk, rst                       clock, asynchronous active-high reset
//          s_axis_*                       raw frame input (keep ignored)
//          m_axis_*                       payload output via a 2-entry skid buffer
//          hdr_valid, hdr_*               accepted MPI header sideband
//          drop_cnt, len_err_cnt          saturating error counters

module mpi_eth_rx_parser
  import mpi_eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR_LOCAL = 48'hfa163e55ca02,
  parameter logic [15:0] ETHERTYPE      = DEFAULT_ETHERTYPE,
  parameter logic [15:0] MY_RANK        = 16'd1,
  parameter int          ERR_CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          s_axis_data,
  input  logic [7:0]           s_axis_keep,
  input  logic                 s_axis_last,
  input  logic                 s_axis_valid,
  output logic                 s_axis_ready,
  output logic [63:0]          m_axis_data,
  output logic [7:0]           m_axis_keep,
  output logic                 m_axis_last,
  output logic                 m_axis_valid,
  input  logic                 m_axis_ready,
  output logic                 hdr_valid,
  output logic [47:0]          hdr_src_mac,
  output logic [7:0]           hdr_src_rank,
  output logic [7:0]           hdr_msg_type,
  output logic [31:0]          hdr_size,
  output logic [ERR_CNT_W-1:0] drop_cnt,
  output logic [ERR_CNT_W-1:0] len_err_cnt
);

  state_t                r_state;
  logic                  r_live;      // holds s_axis_ready low for the cycle after reset
  logic [15:0]           r_src_up;
  logic [31:0]           r_src_dn;
  logic [31:0]           r_flit_cnt;
  logic                  r_odd;
  logic                  r_hdr_valid;
  logic [47:0]           r_hdr_src_mac;
  logic [7:0]            r_hdr_src_rank;
  logic [7:0]            r_hdr_msg_type;
  logic [31:0]           r_hdr_size;
  logic [ERR_CNT_W-1:0]  r_drop_cnt;
  logic [ERR_CNT_W-1:0]  r_len_err_cnt;

  logic                  w_hs;
  logic                  w_final;
  logic                  w_push;
  logic                  w_skid_ready;
  logic [7:0]            w_keep;
  logic                  w_last;
  logic                  w_drop_inc;
  logic                  w_len_inc;
  logic                  w_mac_bad;
  logic                  w_etype_bad;
  logic                  w_rank_bad;
  logic                  w_unused_keep;
  mpi_hdr_t              w_hdr;

  assign w_unused_keep = ^s_axis_keep;

  assign w_hdr       = mpi_hdr_t'(s_axis_data);
  assign w_mac_bad   = (s_axis_data[DST_MAC_HI:DST_MAC_LO] != MAC_ADDR_LOCAL);
  assign w_etype_bad = (s_axis_data[ETYPE_HI:ETYPE_LO] != ETHERTYPE);
  assign w_rank_bad  = (s_axis_data[RANK_HI:RANK_LO] != MY_RANK);

  // Only the payload state is throttled by the output buffer.
  assign s_axis_ready = r_live & ((r_state != ST_PAYLOAD) | w_skid_ready);
  assign w_hs         = s_axis_valid & s_axis_ready;

  assign w_final = (r_flit_cnt == 32'd1);
  assign w_push  = w_hs & (r_state == ST_PAYLOAD);
  // An odd word count leaves only the upper 32-bit word valid in the final flit.
  assign w_keep  = (w_final & r_odd) ? 8'hf0 : 8'hff;
  assign w_last  = w_final | s_axis_last;

  always_comb begin
    w_drop_inc = 1'b0;
    w_len_inc  = 1'b0;
    if (w_hs) begin
      case (r_state)
        ST_ETH0: w_drop_inc = s_axis_last | w_mac_bad;
        ST_ETH1: w_drop_inc = s_axis_last | w_etype_bad;
        ST_MPI: begin
          if (w_rank_bad) begin
            w_drop_inc = 1'b1;
          end else begin
            w_len_inc = (w_hdr.size == 32'd0) ? ~s_axis_last : s_axis_last;
          end
        end
        ST_PAYLOAD: w_len_inc = w_final ? ~s_axis_last : s_axis_last;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_ETH0;
      r_live         <= 1'b0;
      r_src_up       <= '0;
      r_src_dn       <= '0;
      r_flit_cnt     <= '0;
      r_odd          <= 1'b0;
      r_hdr_valid    <= 1'b0;
      r_hdr_src_mac  <= '0;
      r_hdr_src_rank <= '0;
      r_hdr_msg_type <= '0;
      r_hdr_size     <= '0;
      r_drop_cnt     <= '0;
      r_len_err_cnt  <= '0;
    end else begin
      r_live      <= 1'b1;
      r_hdr_valid <= 1'b0;

      if (w_drop_inc && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + ERR_CNT_W'(1);
      end
      if (w_len_inc && (r_len_err_cnt != '1)) begin
        r_len_err_cnt <= r_len_err_cnt + ERR_CNT_W'(1);
      end

      if (w_hs) begin
        case (r_state)
          ST_ETH0: begin
            r_src_up <= s_axis_data[SRC_MAC_UP_HI:SRC_MAC_UP_LO];
            if (s_axis_last)    r_state <= ST_ETH0;
            else if (w_mac_bad) r_state <= ST_DROP;
            else                r_state <= ST_ETH1;
          end
          ST_ETH1: begin
            r_src_dn <= s_axis_data[SRC_MAC_DN_HI:SRC_MAC_DN_LO];
            if (s_axis_last)      r_state <= ST_ETH0;
            else if (w_etype_bad) r_state <= ST_DROP;
            else                  r_state <= ST_MPI;
          end
          ST_MPI: begin
            if (w_rank_bad) begin
              r_state <= s_axis_last ? ST_ETH0 : ST_DROP;
            end else begin
              r_hdr_valid    <= 1'b1;
              r_hdr_src_mac  <= {r_src_up, r_src_dn};
              r_hdr_src_rank <= w_hdr.src_rank;
              r_hdr_msg_type <= w_hdr.msg_type;
              r_hdr_size     <= s_axis_data[SIZE_HI:SIZE_LO];
              r_flit_cnt     <= flits_for_words(w_hdr.size);
              r_odd          <= w_hdr.size[0];
              if (s_axis_last)              r_state <= ST_ETH0;
              else if (w_hdr.size == 32'd0) r_state <= ST_DROP;
              else                          r_state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            if (w_final)          r_state <= s_axis_last ? ST_ETH0 : ST_DROP;
            else if (s_axis_last) r_state <= ST_ETH0;
            else                  r_flit_cnt <= r_flit_cnt - 32'd1;
          end
          ST_DROP: begin
            if (s_axis_last) r_state <= ST_ETH0;
          end
          default: r_state <= ST_ETH0;
        endcase
      end
    end
  end

  axis_skid_buf #(
    .DW(64),
    .KW(8)
  ) u_skid (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  (s_axis_data),
    .i_keep  (w_keep),
    .i_last  (w_last),
    .i_valid (w_push),
    .o_ready (w_skid_ready),
    .o_data  (m_axis_data),
    .o_keep  (m_axis_keep),
    .o_last  (m_axis_last),
    .o_valid (m_axis_valid),
    .i_ready (m_axis_ready)
  );

  assign hdr_valid    = r_hdr_valid;
  assign hdr_src_mac  = r_hdr_src_mac;
  assign hdr_src_rank = r_hdr_src_rank;
  assign hdr_msg_type = r_hdr_msg_type;
  assign hdr_size     = r_hdr_size;
  assign drop_cnt     = r_drop_cnt;
  assign len_err_cnt  = r_len_err_cnt;

endmodule
